// File: rtl/memory_stage_if.sv
// Execute-to-memory-stage bundle, data-memory req/ack bus and registered writeback outputs.
// master = the memory stage itself, slave = the surrounding pipeline and memory.
interface memory_stage_if;
   logic        in_valid;
   logic [4:0]  rd;
   logic [31:0] out;
   logic [31:0] vt;
   logic [10:8] signal;
   logic        stall;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        wb_valid;
   logic        wb_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_value;
   logic        fault;

   modport master (
      input  in_valid, rd, out, vt, signal, mem_ack, mem_rdata,
      output stall, mem_req, mem_we, mem_addr, mem_wdata,
      output wb_valid, wb_write, wb_rd, wb_value, fault
   );

   modport slave (
      output in_valid, rd, out, vt, signal, mem_ack, mem_rdata,
      input  stall, mem_req, mem_we, mem_addr, mem_wdata,
      input  wb_valid, wb_write, wb_rd, wb_value, fault
   );
endinterface

// File: rtl/memory_stage.sv
// MIPS memory stage: word load/store over req/ack, registered writeback; MEM_ALIGN_CHECK_EN enables misaligned faults.
// ALU ops 1 cycle, memory ops N+2 cycles; stall holds upstream for the whole transaction, ack cycle included.
module memory_stage (
   input  logic           clk,
   input  logic           reset,
   memory_stage_if.master bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      r_state;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [4:0]  r_rd;
   logic        r_reg_write;

   logic        r_wb_valid;
   logic        r_wb_write;
   logic [4:0]  r_wb_rd;
   logic [31:0] r_wb_value;
   logic        r_fault;

   logic        w_busy;
   logic        w_mem_op;
   logic        w_misaligned;

   assign w_busy   = (r_state == BUSY);
   assign w_mem_op = bus.signal[8] | bus.signal[9];

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = (bus.out[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   assign bus.stall     = w_busy;
   assign bus.mem_req   = w_busy;
   assign bus.mem_we    = w_busy ? r_we    : 1'b0;
   assign bus.mem_addr  = w_busy ? r_addr  : 32'h0;
   assign bus.mem_wdata = w_busy ? r_wdata : 32'h0;

   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_write  = r_wb_write;
   assign bus.wb_rd     = r_wb_rd;
   assign bus.wb_value  = r_wb_value;
   assign bus.fault     = r_fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_rd        <= 5'd0;
         r_reg_write <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_write  <= 1'b0;
         r_wb_rd     <= 5'd0;
         r_wb_value  <= 32'h0;
         r_fault     <= 1'b0;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!bus.in_valid) begin
                  r_wb_valid <= 1'b0;
               end else if (!w_mem_op) begin
                  r_wb_valid <= 1'b1;
                  r_wb_rd    <= bus.rd;
                  r_wb_value <= bus.out;
                  r_wb_write <= bus.signal[10] && (bus.rd != 5'd0);
               end else if (w_misaligned) begin
                  // Rejected access retires as a non-writing instruction.
                  r_wb_valid <= 1'b1;
                  r_wb_write <= 1'b0;
                  r_fault    <= 1'b1;
               end else begin
                  // mem_write wins when both read and write are set.
                  r_we        <= bus.signal[8];
                  r_addr      <= {bus.out[31:2], 2'b00};
                  r_wdata     <= bus.vt;
                  r_rd        <= bus.rd;
                  r_reg_write <= bus.signal[10];
                  r_wb_valid  <= 1'b0;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               if (!bus.mem_ack) begin
                  r_wb_valid <= 1'b0;
               end else begin
                  r_wb_valid <= 1'b1;
                  if (r_we) begin
                     r_wb_write <= 1'b0;
                     r_wb_value <= 32'h0;
                  end else begin
                     r_wb_rd    <= r_rd;
                     r_wb_value <= bus.mem_rdata;
                     r_wb_write <= r_reg_write && (r_rd != 5'd0);
                  end
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage between execute and writeback in the MIPS pipeline. It consumes the execute-stage results: ALU result, destination register, forwarded `vt` store data and memory control bits. It performs word loads and stores over a req/ack data-memory bus and registers the writeback bundle. The stage stalls upstream while a memory transaction is outstanding.

## Interface
No parameters.
- `clk` in 1 — rising-edge clock
- `reset` in 1 — synchronous, active-high
- `in_valid` in 1 — execute stage presents an instruction this cycle
- `rd` in 5 — destination register from execute
- `out` in 32 — ALU result; the memory address for loads and stores
- `vt` in 32 — store data
- `signal` in [10:8] — [8] mem_write, [9] mem_read, [10] reg_write
- `stall` out 1 — upstream must hold its outputs; input is not accepted
- `mem_req` out 1 — data-memory request
- `mem_we` out 1 — 1 = store
- `mem_addr` out 32 — word address, `{addr[31:2],2'b00}`
- `mem_wdata` out 32 — store data
- `mem_ack` in 1 — memory completes the request this cycle
- `mem_rdata` in 32 — load data, valid when `mem_ack`=1
- `wb_valid` out 1 — writeback bundle valid (registered)
- `wb_write` out 1 — register file write enable (registered)
- `wb_rd` out 5 — writeback register (registered)
- `wb_value` out 32 — writeback data (registered)
- `fault` out 1 — misaligned-access pulse (registered)

## Operation
- FSM states: IDLE, BUSY. Hold registers capture op, addr, wdata, rd and reg_write on entry to BUSY.
- `stall` = (state==BUSY). `mem_req` = (state==BUSY). While BUSY, `mem_we`/`mem_addr`/`mem_wdata` come from the hold registers and are stable until ack. In IDLE they are 0.
- IDLE, `in_valid`=0: `wb_valid`<=0.
- IDLE, `in_valid`=1, no memory op:
  - `wb_valid`<=1, `wb_rd`<=rd, `wb_value`<=out.
  - `wb_write`<=reg_write && rd!=0.
- IDLE, `in_valid`=1, memory op (mem_read or mem_write): capture into the hold registers, `wb_valid`<=0, go BUSY.
- If both mem_read and mem_write are set, the op is a store.
- BUSY, `mem_ack`=0: stay BUSY, `wb_valid`<=0.
- BUSY, `mem_ack`=1, load:
  - `wb_valid`<=1, `wb_rd`<=held rd, `wb_value`<=mem_rdata.
  - `wb_write`<=held reg_write && held rd!=0.
  - Go IDLE.
- BUSY, `mem_ack`=1, store: `wb_valid`<=1, `wb_write`<=0, `wb_value`<=0, go IDLE.
- The ack cycle still stalls, so there is no back-to-back acceptance at ack. The next instruction is accepted in the cycle after ack.
- `mem_ack` is ignored in IDLE.

## Timing
- Reset:
  - state IDLE.
  - `wb_valid`, `wb_write`, `wb_rd`, `wb_value`, `fault` all 0.
  - Hold registers are cleared, so `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` read 0 after the reset edge.
- Reset during BUSY abandons the transaction: `mem_req` drops the cycle after the reset edge and no writeback occurs. The memory must tolerate an abandoned request.
- Non-memory op latency: 1 cycle from acceptance edge to `wb_valid`. Throughput is 1 per cycle.
- Memory op:
  - `mem_req` rises the cycle after acceptance.
  - For an ack N cycles after `mem_req` rises (N≥0), `wb_valid` rises on the edge ending the ack cycle. Total latency is N+2.
  - Minimum spacing between accepted memory ops is 2 cycles.
- `wb_*` hold their value except `wb_valid`, which is a single-cycle flag per instruction.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A memory op in IDLE with out[1:0]!=0 is not issued and stays IDLE.
  - `wb_valid`<=1, `wb_write`<=0, `fault`<=1 for one cycle.
  - `fault` is 0 otherwise.
- Not defined: `fault` is tied 0 and address bits [1:0] are ignored; the access proceeds to the aligned word.

## Test plan
- Reset, then ALU op rd=5, out=0x1234: next cycle `wb_valid`=1, `wb_write`=1, `wb_rd`=5, `wb_value`=0x1234, `stall` never asserted.
- ALU op with rd=0, reg_write=1 -> `wb_valid`=1, `wb_write`=0.
- Load out=0x100, ack 3 cycles after req with rdata=0xDEADBEEF:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=0x100 stable for 4 cycles.
  - `stall`=1 over the same span.
  - Then `wb_value`=0xDEADBEEF, `wb_write`=1.
- Store out=0x40, vt=0xCAFE0001, ack immediately: one cycle of `mem_req` with `mem_we`=1, `mem_wdata`=0xCAFE0001, then `wb_valid`=1, `wb_write`=0.
- Reset asserted during BUSY, with ack arriving after reset: `mem_req` is 0 after the reset edge, no `wb_valid`, and the ack is ignored.
- Load at out=0x102:
  - With `MEM_ALIGN_CHECK_EN`: no `mem_req`, `fault`=1 for one cycle, `wb_write`=0.
  - Without it: `mem_addr`=0x100 and a normal load completes.
